coffee_dispense_sequencer: RTL and testbench

Timed dispensing controller for the coffee machine. It is the consumer side of the per-ingredient time lookup. It drives coffee_type and state into that lookup and reads back ingredient_time (seconds, combinational). It then opens one ingredient valve at a time for that many seconds, stepping through water, coffee, milk, chocolate and sugar. It sits between the front-panel selection logic and the valve/LED drivers.

---
 rtl/coffee_dispense_sequencer_if.sv | 25 ++
 rtl/coffee_dispense_sequencer.sv | 151 +++++++++++++++
 tb/tb_coffee_dispense_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/coffee_dispense_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : coffee_dispense_sequencer_if
// Description : Link between the dispense sequencer and the per-ingredient
//               time lookup (drink/ingredient out, seconds back).
// Revision    : 1.0 - initial release
// ============================================================================
interface coffee_dispense_sequencer_if;
    logic [2:0] coffee_type;
    logic [2:0] state;
    logic [2:0] ingredient_time;

    modport master (
        output coffee_type,
        output state,
        input  ingredient_time
    );

    modport slave (
        input  coffee_type,
        input  state,
        output ingredient_time
    );
endinterface
`default_nettype wire

// File: rtl/coffee_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : coffee_dispense_sequencer
// Description : Opens one ingredient valve at a time for the number of seconds
//               returned by the time lookup. Optional abort input is enabled
//               by defining COFFEE_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module coffee_dispense_sequencer #(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int PRESC_W     = 26
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   start,
    input  wire logic [2:0]             coffee_sel,
`ifdef COFFEE_ABORT_EN
    input  wire logic                   abort,
`endif
    coffee_dispense_sequencer_if.master lookup,
    output logic [4:0]                  valve,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  remaining
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_POUR = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [PRESC_W-1:0] c_PRESC_TERM = PRESC_W'(CLK_PER_SEC - 1);
    localparam logic [2:0]         c_LAST_ING   = 3'd4;

    logic [1:0]         r_fsm;
    logic [2:0]         r_coffee_type;
    logic [2:0]         r_state;
    logic [2:0]         r_remaining;
    logic [4:0]         r_valve;
    logic               r_busy;
    logic               r_done;
    logic [PRESC_W-1:0] r_presc;

    logic w_abort;
    logic w_sel_ok;
    logic w_tick;

`ifdef COFFEE_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_sel_ok = (coffee_sel >= 3'd1) && (coffee_sel <= 3'd4);
    assign w_tick   = (r_presc == c_PRESC_TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm         <= c_ST_IDLE;
            r_coffee_type <= 3'd0;
            r_state       <= 3'd0;
            r_remaining   <= 3'd0;
            r_valve       <= 5'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_presc       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                c_ST_IDLE: begin
                    if (start && w_sel_ok) begin
                        r_coffee_type <= coffee_sel;
                        r_state       <= 3'd0;
                        r_busy        <= 1'b1;
                        r_fsm         <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    if (w_abort) begin
                        r_valve     <= 5'd0;
                        r_remaining <= 3'd0;
                        r_presc     <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= 3'd0;
                        r_fsm       <= c_ST_IDLE;
                    end else begin
                        r_remaining <= lookup.ingredient_time;
                        r_presc     <= '0;
                        if (lookup.ingredient_time != 3'd0) begin
                            r_valve <= 5'b00001 << r_state;
                            r_fsm   <= c_ST_POUR;
                        end else if (r_state == c_LAST_ING) begin
                            r_done <= 1'b1;
                            r_fsm  <= c_ST_DONE;
                        end else begin
                            // Zero-time ingredient: move straight to the next lookup
                            r_state <= r_state + 3'd1;
                        end
                    end
                end
                c_ST_POUR: begin
                    if (w_abort) begin
                        r_valve     <= 5'd0;
                        r_remaining <= 3'd0;
                        r_presc     <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= 3'd0;
                        r_fsm       <= c_ST_IDLE;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        if (r_remaining == 3'd1) begin
                            r_valve     <= 5'd0;
                            r_remaining <= 3'd0;
                            if (r_state == c_LAST_ING) begin
                                r_done <= 1'b1;
                                r_fsm  <= c_ST_DONE;
                            end else begin
                                r_state <= r_state + 3'd1;
                                r_fsm   <= c_ST_LOAD;
                            end
                        end else begin
                            r_remaining <= r_remaining - 3'd1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_valve <= 5'd0;
                    r_busy  <= 1'b0;
                    r_state <= 3'd0;
                    r_fsm   <= c_ST_IDLE;
                end
                default: begin
                    r_valve <= 5'd0;
                    r_busy  <= 1'b0;
                    r_fsm   <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign lookup.coffee_type = r_coffee_type;
    assign lookup.state       = r_state;
    assign valve              = r_valve;
    assign busy               = r_busy;
    assign done               = r_done;
    assign remaining          = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_coffee_dispense_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_coffee_dispense_sequencer
// Description : Scoreboard bench; the bench acts as the time lookup and
//               predicts every busy cycle from the ingredient-time table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coffee_dispense_sequencer;

    localparam int c_CPS = 4;

    typedef struct packed {
        logic [4:0] valve;
        logic [2:0] st;
        logic [2:0] rem;
        logic       done;
        logic [2:0] ct;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] coffee_sel = 3'd0;
    logic       abort = 1'b0;
    logic [4:0] valve;
    logic       busy;
    logic       done;
    logic [2:0] remaining;

    logic [2:0] tbl [0:7][0:4];
    exp_t       q[$];
    int         tests = 0;
    int         fails = 0;

    coffee_dispense_sequencer_if lk ();

    coffee_dispense_sequencer #(.CLK_PER_SEC(c_CPS), .PRESC_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .coffee_sel (coffee_sel),
`ifdef COFFEE_ABORT_EN
        .abort      (abort),
`endif
        .lookup     (lk.master),
        .valve      (valve),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    always_comb begin
        lk.ingredient_time = 3'd0;
        if (lk.state <= 3'd4)
            lk.ingredient_time = tbl[lk.coffee_type][lk.state];
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_row(input logic [2:0] sel, input logic [2:0] a, b, c, d, e);
        tbl[sel][0] = a; tbl[sel][1] = b; tbl[sel][2] = c;
        tbl[sel][3] = d; tbl[sel][4] = e;
    endtask

    // Expected output of every busy cycle: five lookups, each followed by
    // t seconds of its valve, then the one-cycle done.
    function automatic int push_trace(input logic [2:0] sel);
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            q.push_back('{5'd0, 3'(i), 3'd0, 1'b0, sel});
            n++;
            for (int s = int'(tbl[sel][i]); s >= 1; s--) begin
                for (int k = 0; k < c_CPS; k++) begin
                    q.push_back('{5'(1 << i), 3'(i), 3'(s), 1'b0, sel});
                    n++;
                end
            end
        end
        q.push_back('{5'd0, 3'd4, 3'd0, 1'b1, sel});
        return n + 1;
    endfunction

    // Monitor: pops one expectation per busy cycle, checks quiet outputs otherwise
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_busy: got busy=1 valve=%b expected busy=0", valve);
                end else begin
                    exp_t e;
                    exp_t a;
                    e = q.pop_front();
                    a = '{valve, lk.state, remaining, done, lk.coffee_type};
                    if (a !== e) begin
                        fails++;
                        $display("FAIL busy_cycle: got valve=%b st=%0d rem=%0d done=%b ct=%0d expected valve=%b st=%0d rem=%0d done=%b ct=%0d",
                                 a.valve, a.st, a.rem, a.done, a.ct, e.valve, e.st, e.rem, e.done, e.ct);
                    end
                end
            end else begin
                tests++;
                if (valve != 5'd0 || done) begin
                    fails++;
                    $display("FAIL idle_outputs: got valve=%b done=%b expected valve=00000 done=0", valve, done);
                end
            end
        end
    end

    task automatic brew(input logic [2:0] sel, input bit hold_req);
        bit valid;
        bit hold;
        int len;
        int budget;
        valid = (sel >= 3'd1) && (sel <= 3'd4);
        hold  = hold_req && valid;
        len   = 0;
        @(negedge clk); #1;
        start = 1'b1;
        coffee_sel = sel;
        if (valid) len = push_trace(sel);
        if (hold) len = push_trace(sel);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        if (!valid) begin
            repeat (3) @(negedge clk);
            chk("invalid_sel_busy", int'(busy), 0);
            return;
        end
        budget = 400;
        while ((q.size() != 0 || busy) && budget > 0) begin
            @(negedge clk); #1;
            budget--;
            if (hold) begin
                if (q.size() < len) start = 1'b0;
            end else if (q.size() > 1) begin
                // Noise while busy: must neither restart nor change the drink
                start = 1'($urandom_range(0, 1));
                coffee_sel = 3'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (budget == 0) begin
            tests++;
            fails++;
            $display("FAIL brew_timeout: got queue=%0d busy=%b expected queue=0 busy=0", q.size(), busy);
            q.delete();
        end
    endtask

    task automatic reset_mid_pour();
        int budget = 100;
        void'(push_trace(3'd1));
        @(negedge clk); #1;
        start = 1'b1;
        coffee_sel = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!(lk.state == 3'd1 && valve == 5'b00010) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("reach_coffee_pour", int'(budget > 0), 1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_valve", int'(valve), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_state", int'(lk.state), 0);
        chk("rst_coffee_type", int'(lk.coffee_type), 0);
        q.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

`ifdef COFFEE_ABORT_EN
    task automatic abort_case(input logic [2:0] sel, input bit at_end);
        int budget = 200;
        void'(push_trace(sel));
        @(negedge clk); #1;
        start = 1'b1;
        coffee_sel = sel;
        @(posedge clk); #1;
        start = 1'b0;
        while (budget > 0 && (at_end ? (q.size() != 1)
                                     : !(lk.state == 3'd1 && valve == 5'b00010))) begin
            @(negedge clk); #1;
            budget--;
        end
        chk("abort_reach_point", int'(budget > 0), 1);
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        chk("abort_valve", int'(valve), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        q.delete();
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        for (int s = 0; s < 8; s++)
            for (int i = 0; i < 5; i++)
                tbl[s][i] = 3'd0;
        set_row(3'd1, 3'd3, 3'd4, 3'd1, 3'd1, 3'd2);
        set_row(3'd2, 3'd3, 3'd3, 3'd2, 3'd0, 3'd1);
        set_row(3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd1);
        set_row(3'd4, 3'd3, 3'd2, 3'd2, 3'd3, 3'd1);

        repeat (2) @(negedge clk);
        chk("reset_valve", int'(valve), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_remaining", int'(remaining), 0);
        chk("reset_state", int'(lk.state), 0);
        chk("reset_coffee_type", int'(lk.coffee_type), 0);
        #1;
        rst_n = 1'b1;

        brew(3'd1, 1'b0);            // espresso
        brew(3'd4, 1'b0);            // mocaccino
        brew(3'd0, 1'b0);            // invalid selects
        brew(3'd6, 1'b0);
        brew(3'd3, 1'b0);            // cappuccino, zero-time milk, noisy start
        brew(3'd2, 1'b1);            // start held high across two brews
        reset_mid_pour();
        brew(3'd1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [2:0] sel;
            sel = 3'($urandom_range(0, 7));
            for (int i = 0; i < 5; i++)
                tbl[sel][i] = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 3));
            brew(sel, $urandom_range(0, 5) == 0);
        end

`ifdef COFFEE_ABORT_EN
        set_row(3'd1, 3'd3, 3'd4, 3'd1, 3'd1, 3'd2);
        abort_case(3'd1, 1'b0);
        set_row(3'd2, 3'd1, 3'd1, 3'd1, 3'd0, 3'd2);
        abort_case(3'd2, 1'b1);
        brew(3'd1, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
